cpu_mem_arbiter: RTL and testbench

- Shares one sram-like memory port between the instruction-fetch and data-access channels of the 5-stage pipeline.
- Arbitrates address phases with data priority and a bounded-starvation guard for fetch.
- Holds a grant stable until the address handshake completes.
- Tracks outstanding transactions in an in-order owner FIFO and steers each returning response to the requester that issued it.
- Sits between the IF/EX/MEM stages and the memory bridge.

---
 rtl/cpu_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// Shares one sram-like memory port between the fetch and data channels.
// Data-priority address arbitration with a fetch starvation guard, plus in-order response steering.
//
// lock state | meaning
// LOCK_NONE  | no address phase pending, grant chosen fresh each cycle
// LOCK_INST  | fetch address issued but not yet accepted, grant held on fetch
// LOCK_DATA  | data address issued but not yet accepted, grant held on data
module cpu_mem_arbiter #(
    parameter int OUTSTANDING     = 4,
    parameter int DATA_STREAK_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int SW = (DATA_STREAK_MAX > 0) ? $clog2(DATA_STREAK_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_FULL   = CW'(OUTSTANDING);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_e;

    lock_e                  lock_q, lock_d;
    logic [SW-1:0]          streak_q, streak_d;
    logic [OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic grant_valid;
    logic grant_data;
    logic full;
    logic hs;
    logic pop;
    logic head;

    always_comb begin
        grant_valid = 1'b0;
        grant_data  = 1'b0;
        if (lock_q == LOCK_INST) begin
            grant_valid = 1'b1;
        end else if (lock_q == LOCK_DATA) begin
            grant_valid = 1'b1;
            grant_data  = 1'b1;
        end else if (data_req && !(inst_req && streak_q == STREAK_MAX)) begin
            grant_valid = 1'b1;
            grant_data  = 1'b1;
        end else if (inst_req) begin
            grant_valid = 1'b1;
        end
    end

    // With no grant grant_data is 0, so the payload defaults to the fetch channel.
    assign mem_wr    = grant_data ? data_wr    : inst_wr;
    assign mem_size  = grant_data ? data_size  : inst_size;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    assign mem_wdata = grant_data ? data_wdata : inst_wdata;

    assign full    = (count_q == CNT_FULL);
    assign mem_req = grant_valid && (grant_data ? data_req : inst_req) && !full;
    assign hs      = mem_req && mem_addr_ok;

    assign inst_addr_ok = hs && !grant_data;
    assign data_addr_ok = hs && grant_data;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign pop  = mem_data_ok && (count_q != '0);
    assign head = owner_q[rd_ptr_q];

    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        lock_d   = lock_q;
        streak_d = streak_q;
        owner_d  = owner_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (hs) begin
            lock_d = LOCK_NONE;
        end else if (mem_req) begin
            lock_d = grant_data ? LOCK_DATA : LOCK_INST;
        end

        if (hs) begin
            if (grant_data && inst_req) begin
                streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = '0;
            end
        end

        if (hs) begin
            owner_d[wr_ptr_q] = grant_data;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({hs, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q   <= LOCK_NONE;
            streak_q <= '0;
            owner_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            lock_q   <= lock_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference of the arbitration rules.
module tb_cpu_mem_arbiter;
    localparam int OUT = 4;
    localparam int MAX = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic [3:0]  inst_wstrb = 0;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic [3:0]  data_wstrb = 0;
    logic        mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    cpu_mem_arbiter #(.OUTSTANDING(OUT), .DATA_STREAK_MAX(MAX)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference: owners of in-flight transactions in issue order (0=inst, 1=data).
    int m_q[$];
    bit m_lock_valid = 0;
    int m_lock_owner = 0;
    int m_streak = 0;

    bit s_hs, s_mem_req, s_pop, s_inst_hs, s_data_hs;
    int s_owner;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sample();
        bit gv, req, e_iok, e_dok;
        int owner;
        @(negedge clk);
        gv = 0;
        owner = 0;
        if (m_lock_valid) begin
            gv = 1;
            owner = m_lock_owner;
        end else if (data_req && !(inst_req && m_streak == MAX)) begin
            gv = 1;
            owner = 1;
        end else if (inst_req) begin
            gv = 1;
            owner = 0;
        end
        req = gv && ((owner == 1) ? data_req : inst_req) && (m_q.size() < OUT);
        s_mem_req = req;
        s_owner   = owner;
        s_hs      = req && mem_addr_ok;
        s_inst_hs = s_hs && owner == 0;
        s_data_hs = s_hs && owner == 1;
        s_pop     = mem_data_ok && m_q.size() > 0;
        e_iok = 0;
        e_dok = 0;
        if (s_pop) begin
            e_iok = (m_q[0] == 0);
            e_dok = (m_q[0] == 1);
        end
        if (!reset) begin
            chk("mem_req", 64'(mem_req), 64'(req));
            chk("mem_payload", {mem_wr, mem_size, mem_wstrb, mem_addr},
                (owner == 1) ? {data_wr, data_size, data_wstrb, data_addr}
                             : {inst_wr, inst_size, inst_wstrb, inst_addr});
            chk("mem_wdata", 64'(mem_wdata), (owner == 1) ? 64'(data_wdata) : 64'(inst_wdata));
            chk("addr_ok", {inst_addr_ok, data_addr_ok}, {s_inst_hs, s_data_hs});
            chk("data_ok", {inst_data_ok, data_data_ok}, {e_iok, e_dok});
            chk("rdata", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_lock_valid = 0;
            m_streak = 0;
        end else begin
            if (s_pop) void'(m_q.pop_front());
            if (s_hs) m_q.push_back(s_owner);
            if (s_hs) m_lock_valid = 0;
            else if (s_mem_req) begin
                m_lock_valid = 1;
                m_lock_owner = s_owner;
            end
            if (s_hs) begin
                if (s_owner == 1 && inst_req) m_streak = (m_streak < MAX) ? m_streak + 1 : MAX;
                else m_streak = 0;
            end
        end
        #1;
    endtask

    initial begin
        repeat (2) advance();
        reset = 0;
        sample();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
        advance();

        // Single fetch and its response
        inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
        sample();
        chk("t1_addr", 64'(mem_addr), 64'h1C000000);
        chk("t1_addr_ok", 64'(inst_addr_ok), 64'd1);
        advance();
        inst_req = 0; mem_data_ok = 1; mem_rdata = 32'h02800C0C;
        sample();
        chk("t1_data_ok", 64'(inst_data_ok), 64'd1);
        chk("t1_rdata", 64'(inst_rdata), 64'h02800C0C);
        advance();
        mem_data_ok = 0;

        // Both request: data wins, fetch next cycle
        inst_req = 1; inst_addr = 32'h1C000004;
        data_req = 1; data_wr = 1; data_addr = 32'h00001000; data_wstrb = 4'hF; data_wdata = 32'hCAFE0001;
        sample();
        chk("t2_data_win", {data_addr_ok, inst_addr_ok, mem_wr}, 64'b101);
        advance();
        data_req = 0; data_wr = 0;
        sample();
        chk("t2_inst_next", 64'(inst_addr_ok), 64'd1);
        advance();
        inst_req = 0; mem_data_ok = 1;
        sample(); chk("t2_resp_d", 64'(data_data_ok), 64'd1); advance();
        sample(); chk("t2_resp_i", 64'(inst_data_ok), 64'd1); advance();
        mem_data_ok = 0;

        // Lock holds data grant while fetch arrives
        data_req = 1; data_addr = 32'h00002000; mem_addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_locked_addr", 64'(mem_addr), 64'h00002000);
            chk("t3_no_inst_ok", 64'(inst_addr_ok), 64'd0);
            advance();
            inst_req = 1;
        end
        mem_addr_ok = 1;
        sample(); chk("t3_data_hs", 64'(data_addr_ok), 64'd1); advance();
        data_req = 0;
        sample(); chk("t3_inst_hs", 64'(inst_addr_ok), 64'd1); advance();
        inst_req = 0; mem_data_ok = 1;
        repeat (2) begin sample(); advance(); end
        mem_data_ok = 0;

        // Starvation guard: D,D,D,I,D,D,D,I
        inst_req = 1; data_req = 1; mem_data_ok = 1;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("t4_grant", 64'(data_addr_ok), 64'(i % 4 != 3));
            if (i > 0) chk("t4_resp", 64'(data_data_ok), 64'((i - 1) % 4 != 3));
            advance();
        end
        inst_req = 0; data_req = 0;
        sample(); advance();
        mem_data_ok = 0;

        // Fill the owner FIFO, then free one slot
        inst_req = 1;
        repeat (OUT) begin sample(); advance(); end
        sample();
        chk("t5_full_req", 64'(mem_req), 64'd0);
        chk("t5_full_ok", 64'(inst_addr_ok), 64'd0);
        advance();
        mem_data_ok = 1;
        sample();
        chk("t5_pop_req", 64'(mem_req), 64'd0);
        chk("t5_pop_ok", 64'(inst_data_ok), 64'd1);
        advance();
        mem_data_ok = 0;
        sample(); chk("t5_refill", 64'(inst_addr_ok), 64'd1); advance();
        inst_req = 0;

        // Reset with transactions in flight drops them
        reset = 1; advance(); reset = 0;
        mem_data_ok = 1; mem_rdata = 0;
        sample();
        chk("t6_no_data_ok", {inst_data_ok, data_data_ok}, 64'd0);
        chk("t6_mem_req", 64'(mem_req), 64'd0);
        advance();
        mem_data_ok = 0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!inst_req || s_inst_hs) begin
                inst_req   = ($urandom_range(0, 99) < 55);
                inst_wr    = ($urandom_range(0, 9) == 0);
                inst_size  = 2'($urandom_range(0, 2));
                inst_addr  = $urandom;
                inst_wstrb = 4'($urandom);
                inst_wdata = $urandom;
            end
            if (!data_req || s_data_hs) begin
                data_req   = ($urandom_range(0, 99) < 55);
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wstrb = 4'($urandom);
                data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 2) != 0);
            mem_data_ok = 1'($urandom);
            mem_rdata   = $urandom;
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
